// File: rtl/wave_capture_trig.sv
// Triggered wave capture: detects an edge or auto-timeout trigger on the sample stream and writes
// one decimated offset-binary frame into the idle half of a double-buffered display RAM.
module wave_capture_trig #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_sample_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                           wave_display_idle,
    input  logic        [1:0]              trig_mode,
    input  logic signed [SAMPLE_WIDTH-1:0] trig_level,
    input  logic        [3:0]              decim,
    output logic        [ADDR_BITS:0]      write_address,
    output logic                           write_enable,
    output logic        [OUT_WIDTH-1:0]    write_sample,
    output logic                           read_index,
    output logic                           busy
);

    localparam int unsigned TimeoutWidth = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;
    localparam logic [TimeoutWidth-1:0] TimeoutMax = TimeoutWidth'(AUTO_TIMEOUT);
    localparam bit AutoEn = (AUTO_TIMEOUT != 0);
    localparam logic [ADDR_BITS-1:0] LastIdx = '1;
    localparam logic [OUT_WIDTH-1:0] MsbMask = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

    typedef enum logic [1:0] {StArmed, StActive, StWait} state_e;

    state_e                         state_q, state_d;
    logic signed [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic                           prev_valid_q, prev_valid_d;
    logic        [TimeoutWidth-1:0] timeout_q, timeout_d, timeout_inc;
    logic        [ADDR_BITS-1:0]    frame_idx_q, frame_idx_d, wr_idx;
    logic        [3:0]              decim_cnt_q, decim_cnt_d;
    logic        [3:0]              decim_lat_q, decim_lat_d;
    logic                           read_index_q, read_index_d;

    logic        [ADDR_BITS:0]      write_address_q, write_address_d;
    logic                           write_enable_q, write_enable_d;
    logic        [OUT_WIDTH-1:0]    write_sample_q, write_sample_d;
    logic                           busy_q, busy_d;

    logic                           rise, fall, auto_fire, trigger, do_write;
    logic        [OUT_WIDTH-1:0]    sample_top;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StArmed;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            timeout_q       <= '0;
            frame_idx_q     <= '0;
            decim_cnt_q     <= '0;
            decim_lat_q     <= '0;
            read_index_q    <= 1'b0;
            write_address_q <= '0;
            write_enable_q  <= 1'b0;
            write_sample_q  <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_q          <= prev_d;
            prev_valid_q    <= prev_valid_d;
            timeout_q       <= timeout_d;
            frame_idx_q     <= frame_idx_d;
            decim_cnt_q     <= decim_cnt_d;
            decim_lat_q     <= decim_lat_d;
            read_index_q    <= read_index_d;
            write_address_q <= write_address_d;
            write_enable_q  <= write_enable_d;
            write_sample_q  <= write_sample_d;
            busy_q          <= busy_d;
        end
    end

    // Trigger detection, evaluated against the live mode/level inputs
    always_comb begin
        rise        = prev_valid_q && (prev_q < trig_level) && (new_sample_in >= trig_level);
        fall        = prev_valid_q && (prev_q >= trig_level) && (new_sample_in < trig_level);
        timeout_inc = (timeout_q == TimeoutMax) ? timeout_q : timeout_q + 1'b1;
        auto_fire   = AutoEn && (trig_mode == 2'd3) && (timeout_inc == TimeoutMax);
        unique case (trig_mode)
            2'd0:    trigger = rise;
            2'd1:    trigger = fall;
            2'd2:    trigger = rise | fall;
            default: trigger = rise | auto_fire;
        endcase
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        timeout_d    = timeout_q;
        frame_idx_d  = frame_idx_q;
        decim_cnt_d  = decim_cnt_q;
        decim_lat_d  = decim_lat_q;
        read_index_d = read_index_q;
        wr_idx       = frame_idx_q;
        do_write     = 1'b0;

        if (new_sample_ready) begin
            prev_d       = new_sample_in;
            prev_valid_d = 1'b1;
        end

        unique case (state_q)
            StArmed: begin
                if (new_sample_ready) begin
                    timeout_d = timeout_inc;
                    if (trigger) begin
                        // Triggering sample is frame index 0 and decimation slot 0
                        state_d     = StActive;
                        decim_lat_d = decim;
                        decim_cnt_d = (decim == 4'd0) ? 4'd0 : 4'd1;
                        wr_idx      = '0;
                        frame_idx_d = ADDR_BITS'(1);
                        do_write    = 1'b1;
                    end
                end
            end
            StActive: begin
                if (new_sample_ready) begin
                    decim_cnt_d = (decim_cnt_q == decim_lat_q) ? 4'd0 : decim_cnt_q + 4'd1;
                    if (decim_cnt_q == 4'd0) begin
                        do_write    = 1'b1;
                        frame_idx_d = frame_idx_q + 1'b1;
                        if (frame_idx_q == LastIdx) begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (wave_display_idle) begin
                    state_d      = StArmed;
                    read_index_d = ~read_index_q;
                    prev_valid_d = 1'b0;
                    timeout_d    = '0;
                end
            end
            default: state_d = StArmed;
        endcase
    end

    // Output next-state
    always_comb begin
        sample_top      = new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH];
        write_enable_d  = do_write;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        if (do_write) begin
            write_address_d = {~read_index_q, wr_idx};
            write_sample_d  = sample_top ^ MsbMask;
        end
        busy_d = (state_d != StArmed);
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed bench for wave_capture_trig: expected RAM writes are queued when samples are driven
// and popped when write_enable is seen.
module tb_wave_capture_trig;

    localparam int unsigned SW = 16;
    localparam int unsigned OW = 8;
    localparam int unsigned AB = 8;
    localparam int unsigned AT = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 new_sample_ready = 1'b0;
    logic signed [SW-1:0] new_sample_in = '0;
    logic                 wave_display_idle = 1'b0;
    logic        [1:0]    trig_mode = 2'd0;
    logic signed [SW-1:0] trig_level = '0;
    logic        [3:0]    decim = 4'd0;
    logic        [AB:0]   write_address;
    logic                 write_enable;
    logic        [OW-1:0] write_sample;
    logic                 read_index;
    logic                 busy;

    int total = 0;
    int bad = 0;
    int writes = 0;
    logic [AB+OW:0] exp_q[$];

    always #5 clk = ~clk;

    wave_capture_trig #(
        .SAMPLE_WIDTH(SW),
        .OUT_WIDTH(OW),
        .ADDR_BITS(AB),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in),
        .wave_display_idle(wave_display_idle),
        .trig_mode(trig_mode),
        .trig_level(trig_level),
        .decim(decim),
        .write_address(write_address),
        .write_enable(write_enable),
        .write_sample(write_sample),
        .read_index(read_index),
        .busy(busy)
    );

    function automatic logic [OW-1:0] ofs(input logic signed [SW-1:0] s);
        logic [OW-1:0] t;
        t = s[SW-1 -: OW];
        t[OW-1] = ~t[OW-1];
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int addr, input logic signed [SW-1:0] s);
        logic [AB:0] a;
        a = addr[AB:0];
        exp_q.push_back({a, ofs(s)});
    endtask

    // One clock: drive inputs, take the edge, then score any write the edge produced
    task automatic step(input logic rdy, input logic signed [SW-1:0] s);
        logic [AB+OW:0] e;
        new_sample_ready = rdy;
        new_sample_in    = s;
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
        if (write_enable === 1'b1) begin
            writes++;
            chk("write_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", {23'd0, write_address}, {23'd0, e[AB+OW:OW]});
                chk("wr_sample", {24'd0, write_sample}, {24'd0, e[OW-1:0]});
            end
        end
    endtask

    task automatic idle_pulse();
        wave_display_idle = 1'b1;
        step(1'b0, '0);
        wave_display_idle = 1'b0;
    endtask

    initial begin
        logic signed [SW-1:0] s;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", {23'd0, write_address}, 32'd0);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_sample", {24'd0, write_sample}, 32'd0);
        chk("rst_read_index", {31'd0, read_index}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        // Rising trigger, level 0, no decimation: frame into upper half
        step(1'b1, -16'sd5);
        chk("no_trig_below", {31'd0, busy}, 32'd0);
        push(256, 16'sd3);
        step(1'b1, 16'sd3);
        chk("first_sample", {24'd0, write_sample}, 32'h80);
        for (int k = 1; k < 256; k++) begin
            s = 16'(k * 113 - 14000);
            push(256 + k, s);
            step(1'b1, s);
        end
        chk("t1_drained", exp_q.size(), 32'd0);
        chk("t1_writes", writes, 32'd256);
        chk("t1_busy_wait", {31'd0, busy}, 32'd1);
        step(1'b1, 16'sd500);
        chk("t1_no_wrap_write", writes, 32'd256);
        chk("t1_read_index", {31'd0, read_index}, 32'd0);
        idle_pulse();
        chk("t1_swap", {31'd0, read_index}, 32'd1);
        chk("t1_busy_clear", {31'd0, busy}, 32'd0);

        // Falling-only trigger at level 100, frame into lower half
        trig_mode  = 2'd1;
        trig_level = 16'sd100;
        step(1'b1, 16'sd50);
        step(1'b1, 16'sd150);
        step(1'b1, 16'sd200);
        chk("t2_rise_ignored", writes, 32'd256);
        chk("t2_armed", {31'd0, busy}, 32'd0);
        push(0, 16'sd50);
        step(1'b1, 16'sd50);
        chk("t2_fall_trig", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 256; k++) begin
            s = 16'(32000 - k * 211);
            push(k, s);
            step(1'b1, s);
        end
        chk("t2_drained", exp_q.size(), 32'd0);
        chk("t2_writes", writes, 32'd512);
        idle_pulse();
        chk("t2_swap", {31'd0, read_index}, 32'd0);

        // Auto trigger after 8 readies, decim 3, idle held high throughout
        trig_mode         = 2'd3;
        trig_level        = 16'sd0;
        decim             = 4'd3;
        wave_display_idle = 1'b1;
        for (int n = 1; n < 8; n++) step(1'b1, 16'sd0);
        chk("t3_no_early_auto", writes, 32'd512);
        chk("t3_armed", {31'd0, busy}, 32'd0);
        push(256, 16'sd0);
        step(1'b1, 16'sd0);
        chk("t3_auto_trig", {31'd0, busy}, 32'd1);
        chk("t3_first_sample", {24'd0, write_sample}, 32'h80);
        for (int m = 2; m <= 1021; m++) begin
            s = 16'(m * 37 - 9000);
            if ((m - 1) % 4 == 0) push(256 + (m - 1) / 4, s);
            step(1'b1, s);
            if (m == 10) decim = 4'd0;
            if (m == 1020) chk("t4_not_done_1020", writes, 32'd767);
        end
        chk("t4_writes_1021", writes, 32'd768);
        chk("t4_drained", exp_q.size(), 32'd0);
        chk("t5_no_swap_yet", {31'd0, read_index}, 32'd0);
        chk("t5_busy_wait", {31'd0, busy}, 32'd1);
        step(1'b0, '0);
        chk("t5_swap_next_cycle", {31'd0, read_index}, 32'd1);
        chk("t5_busy_clear", {31'd0, busy}, 32'd0);
        wave_display_idle = 1'b0;

        // Next frame lands at addresses 0.., then reset mid-frame
        trig_mode = 2'd0;
        decim     = 4'd0;
        step(1'b1, -16'sd1);
        push(0, 16'sd1);
        step(1'b1, 16'sd1);
        push(1, 16'sd2);
        step(1'b1, 16'sd2);
        push(2, 16'sd3);
        step(1'b1, 16'sd3);
        chk("t6_writing", {31'd0, write_enable}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_we", {31'd0, write_enable}, 32'd0);
        chk("t6_rst_read_index", {31'd0, read_index}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_addr", {23'd0, write_address}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            s = (i % 2 == 0) ? -16'sd700 : 16'sd700;
            step(1'b1, s);
        end
        chk("t6_no_write_in_reset", writes, 32'd771);
        reset = 1'b1;
        step(1'b1, -16'sd1);
        chk("t6_rearmed", {31'd0, busy}, 32'd0);
        push(256, 16'sd1);
        step(1'b1, 16'sd1);
        chk("t6_restart_addr", {23'd0, write_address}, 32'd256);
        chk("t6_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_capture_trig.md
Name: wave_capture_trig

Overview:
- Parametrised successor to the single-mode wave capture block. Watches the audio sample stream and detects a configurable trigger (rising, falling, either edge, or auto with timeout).
- Writes one decimated, offset-binary frame of 2^ADDR_BITS samples into the half of a double-buffered display RAM that the display is not reading.
- Swaps halves when the wave display reports idle. Sits between the codec/sample pipeline and the wave display RAM.

Parameters:
- SAMPLE_WIDTH, 16, signed two's-complement input sample width.
- OUT_WIDTH, 8, stored sample width; must be at most SAMPLE_WIDTH.
- ADDR_BITS, 8, log2 of samples per frame. The RAM holds 2 frames.
- AUTO_TIMEOUT, 4096, ready-samples spent in ARMED before auto mode forces a trigger. 0 disables the forced trigger.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- new_sample_ready  in  1  one-cycle strobe qualifying new_sample_in.
- new_sample_in  in  SAMPLE_WIDTH  signed sample.
- wave_display_idle  in  1  display is not reading RAM; level-sensitive.
- trig_mode  in  2  0=rising, 1=falling, 2=either edge, 3=auto (rising, plus timeout).
- trig_level  in  SAMPLE_WIDTH  signed trigger threshold.
- decim  in  4  store every (decim+1)-th sample after trigger.
- write_address  out  ADDR_BITS+1  {~read_index, frame index}.
- write_enable  out  1  one-cycle RAM write strobe.
- write_sample  out  OUT_WIDTH  offset-binary sample.
- read_index  out  1  half of RAM the display reads.
- busy  out  1  high in ACTIVE or WAIT.

Behaviour:
- All outputs are registered. Reset values: write_address=0, write_enable=0, write_sample=0, read_index=0, busy=0.
- Internal reset state: state ARMED, prev_valid=0, all counters 0.
- Reset asserted mid-frame abandons the frame at once. No further writes occur. read_index returns to 0.
- Sample events: all state changes except the WAIT→ARMED exit happen only on cycles with new_sample_ready=1. Other cycles hold state.
- prev register: loads new_sample_in on every ready. prev_valid sets on the first ready after entering ARMED.
- Edge definitions (signed compare):
  - rise = prev<trig_level && new>=trig_level
  - fall = prev>=trig_level && new<trig_level
  - Both require prev_valid=1.
- ARMED:
  - trig_mode, trig_level and decim are used live.
  - The timeout counter counts ready events and saturates at AUTO_TIMEOUT.
  - Trigger fires on the selected edge. In mode 3 it also fires when the counter reaches AUTO_TIMEOUT (if AUTO_TIMEOUT≠0), even with prev_valid=0.
  - On trigger: latch decim, clear frame index and decimation counter, go ACTIVE.
  - The triggering sample is written as frame index 0 in the same event.
- ACTIVE:
  - On each ready event the decimation counter counts 0..decim_latched and then wraps.
  - A write occurs only when the counter is 0.
  - Write data: write_sample = new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH] with its MSB inverted (two's-complement to offset-binary).
  - Write address: write_address = {~read_index, frame_index}.
  - write_enable rises the cycle after the ready strobe, for exactly one cycle.
  - After writing frame index 2^ADDR_BITS-1, go WAIT. There is no wrap-around write.
- WAIT:
  - No writes. busy=1.
  - The first cycle with wave_display_idle=1 toggles read_index and moves to ARMED, with prev_valid=0 and timeout counter=0. This does not depend on new_sample_ready.
- Simultaneous events:
  - idle high during ACTIVE is ignored.
  - If idle is already high on the cycle WAIT is entered, the exit occurs on the next cycle.
  - A ready strobe coinciding with the WAIT→ARMED transition is not used for trigger detection.
- Latency: frame index 0 is written 1 cycle after the triggering ready strobe. A frame ends 1 cycle after ready event number (2^ADDR_BITS-1)·(decim+1)+1, counting the trigger event as 1.

Test Plan:
- Reset, then mode 0, level 0, decim 0. Feed samples -5 then +3, then 255 further samples → 256 writes at addresses 256..511. First write_sample = 0x80 (+3 top byte 0x00 → 0x80). busy stays 1. Idle pulse → read_index=1 and busy=0.
- Mode 1, level 100. Feed 200 then 50 → trigger on the 50 sample. Feed 150 then 200 while ARMED → no trigger. Falling crossing only.
- Mode 3, AUTO_TIMEOUT=8, constant sample 0 → forced trigger on the 8th ready event. First write has write_sample=0x80.
- decim=3 → write_enable pulses once per 4 ready strobes. 256 writes complete after 1021 events. Changing decim mid-frame has no effect.
- Hold idle high throughout: frame completes → read_index toggles exactly one cycle after WAIT is entered. Next frame writes addresses 0..255.
- Assert reset (low) mid-ACTIVE → write_enable=0 immediately, state ARMED, read_index=0. No write occurs while reset is low.
